// File: rtl/divide_re.sv
// divide_re: sequential signed fractional divider, d_re = trunc(a_re * 2^WIDTH / b_re).
// Uses restoring shift-subtract division on magnitudes, one quotient bit per cycle.
// Results that cannot fit the signed range are clamped, and the sat/div_zero flags are set.
module divide_re #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] b_re,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_re,
  output logic             sat,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic [WIDTH:0]   a_ext, b_ext, mag_a, mag_b;
  logic [WIDTH+1:0] twice_a, mag_b_wide;
  logic             res_neg, b_zero, ovf, sat_in;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   divisor;
  logic [WIDTH-1:0] quo;
  logic             neg;

  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] quo_next, quo_signed;

  // Decode the incoming pair: magnitudes one bit wider so the most negative value does not wrap.
  always_comb begin
    a_ext      = {a_re[WIDTH-1], a_re};
    b_ext      = {b_re[WIDTH-1], b_re};
    mag_a      = a_ext[WIDTH] ? -a_ext : a_ext;
    mag_b      = b_ext[WIDTH] ? -b_ext : b_ext;
    b_zero     = (b_re == '0);
    res_neg    = a_re[WIDTH-1] ^ b_re[WIDTH-1];
    twice_a    = {mag_a, 1'b0};
    mag_b_wide = {1'b0, mag_b};
    ovf        = b_zero || (twice_a >= mag_b_wide);
    sat_in     = b_zero || (twice_a > mag_b_wide) || ((twice_a == mag_b_wide) && !res_neg);
  end

  // One restoring step: shift the remainder, subtract the divisor if it fits, shift in the bit.
  always_comb begin
    rem_sh     = {rem, 1'b0};
    fits       = (rem_sh >= divisor);
    quo_next   = (quo << 1) | WIDTH'(fits);
    quo_signed = neg ? -quo_next : quo_next;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) state_next = ovf ? DONE : CALC;
      end
      CALC: begin
        if (cnt == WIDTH'(1)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on acceptance, iterate in CALC, hold the result through DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      divisor  <= '0;
      quo      <= '0;
      neg      <= 1'b0;
      d_re     <= '0;
      sat      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg      <= res_neg;
            divisor  <= mag_b;
            rem      <= WIDTH'(mag_a);
            quo      <= '0;
            sat      <= sat_in;
            div_zero <= b_zero;
            if (ovf) begin
              d_re <= res_neg ? MIN_NEG : MAX_POS;
              cnt  <= '0;
            end else begin
              cnt  <= WIDTH'(WIDTH);
            end
          end
        end
        CALC: begin
          rem <= fits ? WIDTH'(rem_sh - divisor) : WIDTH'(rem_sh);
          quo <= quo_next;
          cnt <= cnt - WIDTH'(1);
          if (cnt == WIDTH'(1)) d_re <= quo_signed;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_re.sv
// tb_divide_re: randomized and directed checks of divide_re against an arithmetic reference model.
module tb_divide_re;

  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_re, b_re;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d_re;
  logic             sat;
  logic             div_zero;

  int compared = 0;
  int mismatched = 0;

  divide_re #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_re     (a_re),
    .b_re     (b_re),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d_re     (d_re),
    .sat      (sat),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact truncating division on integers, then clamp to the signed range.
  task automatic refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic [WIDTH-1:0] d, output logic s, output logic dz,
                          output int lat);
    longint sa, sb, q, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (WIDTH - 1);
    dz  = (sb == 0);
    if (sb == 0) begin
      d   = (sa >= 0) ? WIDTH'(lim - 1) : WIDTH'(lim);
      s   = 1'b1;
      lat = 1;
    end else begin
      q = (sa * (longint'(1) << WIDTH)) / sb;
      if (q >= lim) begin
        d = WIDTH'(lim - 1); s = 1'b1; lat = 1;
      end else if (q <= -lim) begin
        d = WIDTH'(lim); s = (q < -lim); lat = 1;
      end else begin
        d = q[WIDTH-1:0]; s = 1'b0; lat = WIDTH + 1;
      end
    end
  endtask

  // Run one full transaction: accept, measure latency, hold in DONE, consume, verify return to IDLE.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
    logic [WIDTH-1:0] expD;
    logic expS, expDz;
    int expLat, lat, waitCnt;
    refModel(a, b, expD, expS, expDz, expLat);
    waitCnt = 0;
    while (!in_ready && waitCnt < 100) begin
      @(negedge clock);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1; a_re = a; b_re = b;
    @(negedge clock);
    in_valid = 1'b0; a_re = WIDTH'($urandom); b_re = WIDTH'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom);
      a_re = WIDTH'($urandom); b_re = WIDTH'($urandom);
      @(negedge clock);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    if (!out_valid) return;
    checkOutput("d_re", 32'(d_re), 32'(expD));
    checkOutput("sat", 32'(sat), 32'(expS));
    checkOutput("div_zero", 32'(div_zero), 32'(expDz));
    checkOutput("in_ready_done", 32'(in_ready), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a_re = WIDTH'($urandom); b_re = WIDTH'($urandom);
      @(negedge clock);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_d_re", 32'(d_re), 32'(expD));
      checkOutput("hold_sat", 32'(sat), 32'(expS));
      checkOutput("hold_div_zero", 32'(div_zero), 32'(expDz));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("consumed_valid", 32'(out_valid), 32'd0);
    checkOutput("consumed_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [WIDTH-1:0] dirA [10] = '{16'h1000, 16'hF000, 16'h0001, 16'hFFFF, 16'h2000,
                                  16'hE000, 16'h8000, 16'h0100, 16'hFF00, 16'h0000};
  logic [WIDTH-1:0] dirB [10] = '{16'h4000, 16'h4000, 16'h0003, 16'h0003, 16'h4000,
                                  16'h4000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000};

  initial begin
    int quiet;
    logic [WIDTH-1:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_re = '0; b_re = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_d_re", 32'(d_re), 32'd0);
    checkOutput("reset_sat", 32'(sat), 32'd0);
    checkOutput("reset_div_zero", 32'(div_zero), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);

    applyStimulus(16'h1000, 16'h4000, 5);
    for (int i = 0; i < 10; i++) applyStimulus(dirA[i], dirB[i], i % 3);

    // Abort a division on its 8th CALC cycle with reset.
    in_valid = 1'b1; a_re = 16'h1000; b_re = 16'h4000;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abort_release_in_ready", 32'(in_ready), 32'd1);
    quiet = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (out_valid) quiet++;
    end
    checkOutput("abort_no_result", 32'(quiet), 32'd0);
    applyStimulus(16'h0001, 16'h0003, 1);

    for (int n = 0; n < 150; n++) begin
      ra = WIDTH'($urandom);
      if ($urandom_range(0, 2) == 0) ra = WIDTH'($signed(ra) >>> $urandom_range(1, WIDTH - 1));
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = ($urandom_range(0, 1) == 1) ? -WIDTH'($urandom_range(1, 7)) : WIDTH'($urandom_range(1, 7));
        2:       rb = (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF);
        default: rb = WIDTH'($urandom);
      endcase
      applyStimulus(ra, rb, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
